// File: rtl/inv_linear_transfomation_if.sv
// Sample stream and calibration handshake of the inverse piecewise-linear mapper.
// The DUT connects through the slave modport and the driver through master.
interface inv_linear_transfomation_if #(
    parameter int DSIZE = 12
) ();
    logic                 cal_begin;
    logic                 cal_valid;
    logic [16*DSIZE-1:0]  c_table;
    logic                 in_valid;
    logic [DSIZE-1:0]     indata;
    logic                 out_valid;
    logic [DSIZE-1:0]     outdata;

    modport master (
        output cal_begin, c_table, in_valid, indata,
        input  cal_valid, out_valid, outdata
    );

    modport slave (
        input  cal_begin, c_table, in_valid, indata,
        output cal_valid, out_valid, outdata
    );
endinterface

// File: rtl/inv_linear_transfomation.sv
// Inverse 16-knee piecewise-linear map: y (C knees) -> x (M knees), slopes from a serial divider.
// Latency: 3 cycles per sample, 1 sample/cycle; calibration 15*(DSIZE+DT_D+2)+1 cycles.
// No backpressure: samples arriving while cal_valid=0 are dropped. INV_LT_ROUND_EN selects rounding.
module inv_linear_transfomation #(
    parameter int                  DSIZE   = 12,
    parameter int                  DT_I    = 8,
    parameter int                  DT_D    = 4,
    parameter logic [16*DSIZE-1:0] M_TABLE = {12'd240, 12'd224, 12'd208, 12'd192,
                                              12'd176, 12'd160, 12'd144, 12'd128,
                                              12'd112, 12'd96,  12'd80,  12'd64,
                                              12'd48,  12'd32,  12'd16,  12'd0}
) (
    input logic                       clock,
    input logic                       rst,
    inv_linear_transfomation_if.slave bus
);
    localparam int NW = DSIZE + DT_D;
    localparam int RW = DT_I + DT_D;
    localparam int PW = DSIZE + DT_I + DT_D;
    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);
    localparam logic [RW-1:0] R_MAX    = '1;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NEXT, DONE, READY} state_t;

    function automatic logic [DSIZE-1:0] knee(input logic [16*DSIZE-1:0] tab, input logic [3:0] idx);
        return tab[idx*DSIZE +: DSIZE];
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NW-1:0]       quo_q, quo_d;
    logic [DSIZE-1:0]    rem_q, rem_d;
    logic [DSIZE-1:0]    den_q, den_d;
    logic                flag_q, flag_d;
    logic                cal_valid_q, cal_valid_d;
    logic [16*DSIZE-1:0] c_q, c_d;
    logic [RW-1:0]       r_q [15];
    logic [RW-1:0]       r_d [15];

    logic [DSIZE:0]      m_diff, c_diff, trial;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        den_d       = den_q;
        flag_d      = flag_q;
        cal_valid_d = cal_valid_q;
        c_d         = c_q;
        r_d         = r_q;
        m_diff      = {1'b0, knee(M_TABLE, k_q + 4'd1)} - {1'b0, knee(M_TABLE, k_q)};
        c_diff      = {1'b0, knee(c_q, k_q + 4'd1)} - {1'b0, knee(c_q, k_q)};
        trial       = {rem_q, quo_q[NW-1]};

        case (state_q)
            LOAD: begin
                quo_d   = {m_diff[DSIZE-1:0], {DT_D{1'b0}}};
                den_d   = c_diff[DSIZE-1:0];
                rem_d   = '0;
                cnt_d   = '0;
                // Non-positive differences (MSB is the sign) give a zero slope
                flag_d  = m_diff[DSIZE] || (m_diff == '0) || c_diff[DSIZE] || (c_diff == '0);
                state_d = DIV;
            end
            DIV: begin
                if (trial >= {1'b0, den_q}) begin
                    rem_d = trial[DSIZE-1:0] - den_q;
                    quo_d = {quo_q[NW-2:0], 1'b1};
                end else begin
                    rem_d = trial[DSIZE-1:0];
                    quo_d = {quo_q[NW-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (flag_q) begin
                    r_d[k_q] = '0;
                end else if (quo_q > NW'(R_MAX)) begin
                    r_d[k_q] = R_MAX;
                end else begin
                    r_d[k_q] = quo_q[RW-1:0];
                end
                if (k_q == 4'd14) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                cal_valid_d = 1'b1;
                state_d     = READY;
            end
            default: ;
        endcase

        if (bus.cal_begin) begin
            state_d     = LOAD;
            k_d         = '0;
            c_d         = bus.c_table;
            cal_valid_d = 1'b0;
        end
    end

    // Data path: S1 search, S2 multiply, S3 add/saturate/clamp
    logic             vld1_q, vld1_d, lo1_q, lo1_d, hi1_q, hi1_d;
    logic [3:0]       k1_q, k1_d, k2_q, k2_d, k_s;
    logic [DSIZE-1:0] y1_q, y1_d, ck1_q, ck1_d, dy;
    logic             vld2_q, vld2_d, lo2_q, lo2_d, hi2_q, hi2_d;
    logic [PW-1:0]    p2_q, p2_d;
    logic             out_valid_q, out_valid_d;
    logic [DSIZE-1:0] outdata_q, outdata_d, x;
    logic [PW:0]      p_adj, sum;

    always_comb begin
        k_s = '0;
        for (int i = 1; i < 15; i++) begin
            if (bus.indata >= knee(c_q, 4'(i))) k_s = 4'(i);
        end
        vld1_d = bus.in_valid & cal_valid_q;
        lo1_d  = bus.indata < knee(c_q, 4'd0);
        hi1_d  = bus.indata >= knee(c_q, 4'd15);
        k1_d   = k_s;
        y1_d   = bus.indata;
        ck1_d  = knee(c_q, k_s);

        dy     = y1_q - ck1_q;
        vld2_d = vld1_q;
        lo2_d  = lo1_q;
        hi2_d  = hi1_q;
        k2_d   = k1_q;
        p2_d   = {{RW{1'b0}}, dy} * {{DSIZE{1'b0}}, r_q[k1_q]};

`ifdef INV_LT_ROUND_EN
        p_adj = {1'b0, p2_q} + (PW+1)'(2**(DT_D-1));
`else
        p_adj = {1'b0, p2_q};
`endif
        sum = {{(PW+1-DSIZE){1'b0}}, knee(M_TABLE, k2_q)} + (p_adj >> DT_D);
        x   = (|sum[PW:DSIZE]) ? '1 : sum[DSIZE-1:0];
        if (lo2_q) begin
            x = knee(M_TABLE, 4'd0);
        end else if (hi2_q) begin
            x = knee(M_TABLE, 4'd15);
        end
        out_valid_d = vld2_q;
        outdata_d   = vld2_q ? x : outdata_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            flag_q      <= 1'b0;
            cal_valid_q <= 1'b0;
            c_q         <= '0;
            for (int i = 0; i < 15; i++) r_q[i] <= '0;
            vld1_q      <= 1'b0;
            lo1_q       <= 1'b0;
            hi1_q       <= 1'b0;
            k1_q        <= '0;
            y1_q        <= '0;
            ck1_q       <= '0;
            vld2_q      <= 1'b0;
            lo2_q       <= 1'b0;
            hi2_q       <= 1'b0;
            k2_q        <= '0;
            p2_q        <= '0;
            out_valid_q <= 1'b0;
            outdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            flag_q      <= flag_d;
            cal_valid_q <= cal_valid_d;
            c_q         <= c_d;
            r_q         <= r_d;
            vld1_q      <= vld1_d;
            lo1_q       <= lo1_d;
            hi1_q       <= hi1_d;
            k1_q        <= k1_d;
            y1_q        <= y1_d;
            ck1_q       <= ck1_d;
            vld2_q      <= vld2_d;
            lo2_q       <= lo2_d;
            hi2_q       <= hi2_d;
            k2_q        <= k2_d;
            p2_q        <= p2_d;
            out_valid_q <= out_valid_d;
            outdata_q   <= outdata_d;
        end
    end

    assign bus.cal_valid = cal_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.outdata   = outdata_q;
endmodule

// File: tb/tb_inv_linear_transfomation.sv
// Bench for inv_linear_transfomation: random and directed samples against a
// plain-arithmetic model of the inverse map, checked by a decoupled scoreboard.
module tb_inv_linear_transfomation;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_linear_transfomation_if #(.DSIZE(12)) bus ();

    inv_linear_transfomation dut (
        .clock (clk),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        int y;
        int x;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mon_last = 0;
    bit   tb_cal_ok = 1'b0;
    int   mk[16];
    int   ck[16];
    int   nc[16];
    int   rk[15];

    always @(posedge clk) cyc <= cyc + 1;

    // Inverse map from the knee tables: clamp, find segment, interpolate.
    function automatic int model_x(int y);
        int k;
        int p;
        int x;
        if (y < ck[0]) return mk[0];
        if (y >= ck[15]) return mk[15];
        k = 0;
        for (int i = 1; i < 15; i++) if (y >= ck[i]) k = i;
        p = (y - ck[k]) * rk[k];
`ifdef INV_LT_ROUND_EN
        x = mk[k] + (p + 8) / 16;
`else
        x = mk[k] + p / 16;
`endif
        return (x > 4095) ? 4095 : x;
    endfunction

    // Monitor: every output cycle pops one expectation; idle cycles must hold outdata.
    always @(negedge clk) begin
        if (rst) begin
            mon_last = 0;
        end else if (bus.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid outdata=%0d cyc=%0d required no output", bus.outdata, cyc);
            end else begin
                mon_e = q.pop_front();
                mon_last = mon_e.x;
                if (bus.outdata !== 12'(mon_e.x) || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL sample y=%0d outdata=%0d at cyc %0d required %0d at cyc %0d",
                             mon_e.y, bus.outdata, cyc, mon_e.x, mon_e.cyc);
                end
            end
        end else begin
            checks++;
            if (bus.outdata !== 12'(mon_last) || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold out_valid=%b outdata=%0d required 0/%0d", bus.out_valid, bus.outdata, mon_last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int y);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.indata   = 12'(y);
        if (tb_cal_ok) begin
            e.y   = y;
            e.x   = model_x(y);
            e.cyc = cyc + 3;
            q.push_back(e);
        end
        step();
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic start_cal();
        logic [191:0] t;
        int dm;
        int dc;
        int qq;
        for (int i = 0; i < 16; i++) t[i*12 +: 12] = 12'(nc[i]);
        bus.c_table   = t;
        bus.cal_begin = 1'b1;
        step();
        bus.cal_begin = 1'b0;
        bus.in_valid  = 1'b0;
        tb_cal_ok     = 1'b0;
        for (int i = 0; i < 16; i++) ck[i] = nc[i];
        for (int k = 0; k < 15; k++) begin
            dm = mk[k+1] - mk[k];
            dc = ck[k+1] - ck[k];
            qq = (dm <= 0 || dc <= 0) ? 0 : (dm * 16) / dc;
            rk[k] = (qq > 4095) ? 4095 : qq;
        end
    endtask

    task automatic wait_cal();
        int early = 0;
        for (int i = 1; i <= 270; i++) begin
            step();
            if (bus.cal_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL cal_low_window cal_valid high on %0d of 270 edges, required 0", early);
        end
        step();
        checks++;
        if (bus.cal_valid !== 1'b1) begin
            failures++;
            $display("FAIL cal_rise cal_valid=%b on edge 271, required 1", bus.cal_valid);
        end
        tb_cal_ok = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain %0d samples outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(string name);
        checks++;
        if (bus.cal_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.outdata !== 12'd0) begin
            failures++;
            $display("FAIL %s cal_valid=%b out_valid=%b outdata=%0d required 0/0/0",
                     name, bus.cal_valid, bus.out_valid, bus.outdata);
        end
    endtask

    task automatic random_samples(int n, int ymax);
        for (int i = 0; i < n; i++) begin
            send($urandom_range(0, ymax));
            if ($urandom_range(0, 5) == 0) idle(1);
        end
        drain();
    endtask

    task automatic random_table();
        nc[0] = $urandom_range(0, 20);
        for (int i = 1; i < 16; i++) begin
            case ($urandom_range(0, 9))
                0:       nc[i] = nc[i-1];
                1:       nc[i] = (nc[i-1] > 5) ? nc[i-1] - $urandom_range(1, 5) : nc[i-1];
                default: nc[i] = nc[i-1] + $urandom_range(1, 60);
            endcase
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cal_begin = 1'b0;
        bus.c_table   = '0;
        bus.in_valid  = 1'b0;
        bus.indata    = '0;
        for (int k = 0; k < 16; k++) mk[k] = 16 * k;
        repeat (3) step();
        check_zero("reset_state");
        rst = 1'b0;
        step();

        // Uniform table: every slope 0.5
        for (int i = 0; i < 16; i++) nc[i] = 32 * i;
        start_cal();
        wait_cal();
        send(64); send(70); send(71); send(0); send(480); send(4095); send(479);
        idle(2);
        send(32); send(33); send(447);
        random_samples(30, 600);

        // Clamping at both ends, back-to-back
        nc[0] = 5;
        start_cal();
        wait_cal();
        send(0); send(4095); send(4); send(5); send(6); send(480); send(481);
        random_samples(20, 600);

        // Degenerate segments: C3=C4 and C5<C4
        for (int i = 0; i < 16; i++) nc[i] = 32 * i;
        nc[4] = 96;
        nc[5] = 90;
        start_cal();
        wait_cal();
        send(96); send(95); send(97); send(90); send(89); send(100); send(127); send(128);
        random_samples(20, 600);

        // Steep first segment
        for (int i = 0; i < 16; i++) nc[i] = 32 * i;
        nc[0] = 10;
        nc[1] = 11;
        start_cal();
        wait_cal();
        send(10); send(11); send(9); send(12);
        random_samples(15, 600);

        // Random knee tables
        for (int t = 0; t < 3; t++) begin
            random_table();
            start_cal();
            wait_cal();
            random_samples(25, 1000);
        end

        // Samples in flight across a new calibration keep the old slopes
        for (int i = 0; i < 16; i++) nc[i] = 32 * i;
        send(70);
        send(200);
        bus.in_valid = 1'b1;
        bus.indata   = 12'd333;
        mon_e.y = 333; mon_e.x = model_x(333); mon_e.cyc = cyc + 3;
        q.push_back(mon_e);
        nc[0] = 5;
        start_cal();
        wait_cal();
        send(300); send(3);
        drain();

        // Restart mid-calibration, samples offered while not calibrated
        for (int i = 0; i < 16; i++) nc[i] = 20 * i;
        start_cal();
        begin
            int early = 0;
            for (int i = 0; i < 99; i++) begin
                bus.in_valid = 1'b1;
                bus.indata   = 12'($urandom_range(0, 400));
                step();
                if (bus.cal_valid !== 1'b0) early++;
            end
            checks++;
            if (early != 0) begin
                failures++;
                $display("FAIL restart_window cal_valid high on %0d edges, required 0", early);
            end
        end
        for (int i = 0; i < 16; i++) nc[i] = 24 * i;
        start_cal();
        wait_cal();
        send(50); send(100); send(359); send(360);
        drain();

        // Reset in the middle of the divide phase
        start_cal();
        repeat (30) step();
        rst = 1'b1;
        step();
        check_zero("reset_mid_div");
        rst = 1'b0;
        tb_cal_ok = 1'b0;
        step();
        send(64); send(100);
        idle(5);
        check_zero("after_reset_idle");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
